// File: rtl/deb_multi.sv
// Multi-channel input debouncer: per-channel 2-flop synchronizer, enable-gated stability
// counter, debounced level output and registered rise/fall pulses.
module deb_multi #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CNT_WIDTH  = 8,
    parameter int unsigned STABLE_CNT = 255,
    parameter bit          RESET_VAL  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change
);

    // Count value at which the next disagreeing enabled sample is accepted.
    localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(STABLE_CNT - 1);

    logic [CHANNELS-1:0]  r_s1;
    logic [CHANNELS-1:0]  r_s2;
    logic [CHANNELS-1:0]  r_out;
    logic [CHANNELS-1:0]  r_rise;
    logic [CHANNELS-1:0]  r_fall;
    logic [CNT_WIDTH-1:0] r_cnt [CHANNELS];

    logic [CHANNELS-1:0]  w_diff;
    logic [CHANNELS-1:0]  w_hit;
    logic [CHANNELS-1:0]  w_out_d;
    logic [CHANNELS-1:0]  w_rise_d;
    logic [CHANNELS-1:0]  w_fall_d;
    logic [CNT_WIDTH-1:0] w_cnt_d [CHANNELS];

    always_comb begin
        w_diff   = r_s2 ^ r_out;
        w_hit    = '0;
        w_out_d  = r_out;
        w_cnt_d  = r_cnt;
        w_rise_d = '0;
        w_fall_d = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            w_hit[i] = w_diff[i] && (r_cnt[i] == LP_LAST);
            if (en) begin
                if (!w_diff[i]) begin
                    // Agreement (including a bounce back) restarts the count.
                    w_cnt_d[i] = '0;
                end else if (w_hit[i]) begin
                    w_cnt_d[i]  = '0;
                    w_out_d[i]  = r_s2[i];
                    w_rise_d[i] = r_s2[i];
                    w_fall_d[i] = ~r_s2[i];
                end else begin
                    w_cnt_d[i] = r_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= {CHANNELS{RESET_VAL}};
            r_s2   <= {CHANNELS{RESET_VAL}};
            r_out  <= {CHANNELS{RESET_VAL}};
            r_rise <= '0;
            r_fall <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1   <= in;
            r_s2   <= r_s1;
            r_out  <= w_out_d;
            r_rise <= w_rise_d;
            r_fall <= w_fall_d;
            r_cnt  <= w_cnt_d;
        end
    end

    assign out        = r_out;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign any_change = |(r_rise | r_fall);

endmodule

// File: tb/tb_deb_multi.sv
// Bench for deb_multi: three instances (threshold 4 / reset 0, threshold 4 / reset 1,
// threshold 1) share inputs and are compared every cycle against a run-length model.
module tb_deb_multi;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] in_v;

    logic [3:0] out_a, rise_a, fall_a;
    logic [3:0] out_b, rise_b, fall_b;
    logic [3:0] out_c, rise_c, fall_c;
    logic       any_a, any_b, any_c;

    int checks = 0;
    int errors = 0;

    deb_multi #(.CHANNELS(4), .CNT_WIDTH(8), .STABLE_CNT(4), .RESET_VAL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in_v),
        .out(out_a), .rise(rise_a), .fall(fall_a), .any_change(any_a)
    );
    deb_multi #(.CHANNELS(4), .CNT_WIDTH(8), .STABLE_CNT(4), .RESET_VAL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in_v),
        .out(out_b), .rise(rise_b), .fall(fall_b), .any_change(any_b)
    );
    deb_multi #(.CHANNELS(4), .CNT_WIDTH(2), .STABLE_CNT(1), .RESET_VAL(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in_v),
        .out(out_c), .rise(rise_c), .fall(fall_c), .any_change(any_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: a level is accepted once the twice-delayed input has disagreed with it on
    // threshold consecutive enabled samples; any agreeing enabled sample zeroes the run.
    function automatic int thr_of(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    function automatic bit rv_of(input int d);
        return (d == 1);
    endfunction

    logic [3:0] m_d1 [3];
    logic [3:0] m_d2 [3];
    logic [3:0] m_out [3];
    logic [3:0] m_rise [3];
    logic [3:0] m_fall [3];
    int         m_run [3][4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                m_d1[d]   <= {4{rv_of(d)}};
                m_d2[d]   <= {4{rv_of(d)}};
                m_out[d]  <= {4{rv_of(d)}};
                m_rise[d] <= 4'b0;
                m_fall[d] <= 4'b0;
                for (int c = 0; c < 4; c++) m_run[d][c] <= 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                m_d1[d] <= in_v;
                m_d2[d] <= m_d1[d];
                for (int c = 0; c < 4; c++) begin
                    m_rise[d][c] <= 1'b0;
                    m_fall[d][c] <= 1'b0;
                    if (en && (m_d2[d][c] != m_out[d][c])) begin
                        if (m_run[d][c] + 1 >= thr_of(d)) begin
                            m_out[d][c]  <= m_d2[d][c];
                            m_run[d][c]  <= 0;
                            m_rise[d][c] <= m_d2[d][c];
                            m_fall[d][c] <= ~m_d2[d][c];
                        end else begin
                            m_run[d][c] <= m_run[d][c] + 1;
                        end
                    end else if (en) begin
                        m_run[d][c] <= 0;
                    end
                end
            end
        end
    end

    wire [38:0] w_obs = {out_a, rise_a, fall_a, any_a, out_b, rise_b, fall_b, any_b,
                         out_c, rise_c, fall_c, any_c};
    wire [38:0] m_exp = {m_out[0], m_rise[0], m_fall[0], |(m_rise[0] | m_fall[0]),
                         m_out[1], m_rise[1], m_fall[1], |(m_rise[1] | m_fall[1]),
                         m_out[2], m_rise[2], m_fall[2], |(m_rise[2] | m_fall[2])};

    task automatic settle(input logic [3:0] val, input int n);
        en   = 1'b1;
        in_v = val;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            checks++;
            if (w_obs !== m_exp) begin
                errors++;
                $display("FAIL settle_model t=%0t got %h want %h", $time, w_obs, m_exp);
            end
        end
    endtask

    task automatic test_reset();
        en    = 1'b1;
        in_v  = 4'b0000;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({out_a, out_b, out_c} !== 12'h0F0) begin
            errors++;
            $display("FAIL reset_out got %h want %h", {out_a, out_b, out_c}, 12'h0F0);
        end
        checks++;
        if ({rise_a, fall_a, rise_b, fall_b, rise_c, fall_c, any_a, any_b, any_c} !== 27'h0) begin
            errors++;
            $display("FAIL reset_pulses got %h want 0",
                     {rise_a, fall_a, rise_b, fall_b, rise_c, fall_c, any_a, any_b, any_c});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        settle(4'b0000, 10);
    endtask

    task automatic test_clean_press();
        settle(4'b0000, 4);
        in_v[0] = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            checks++;
            if (w_obs !== m_exp) begin
                errors++;
                $display("FAIL clean_model t=%0t got %h want %h", $time, w_obs, m_exp);
            end
            if (j == 5) begin
                checks++;
                if (out_a !== 4'b0000) begin
                    errors++;
                    $display("FAIL clean_early got %b want %b", out_a, 4'b0000);
                end
            end
            if (j == 6) begin
                checks++;
                if ({out_a, rise_a, fall_a} !== 12'b0001_0001_0000) begin
                    errors++;
                    $display("FAIL clean_accept got %b want %b", {out_a, rise_a, fall_a},
                             12'b0001_0001_0000);
                end
            end
            if (j == 7) begin
                checks++;
                if (rise_a !== 4'b0000) begin
                    errors++;
                    $display("FAIL clean_pulse_width got %b want %b", rise_a, 4'b0000);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int pulses;
        int first_j;
        logic [3:0] pat [6];
        pat = '{4'b0011, 4'b0011, 4'b0001, 4'b0001, 4'b0011, 4'b0011};
        settle(4'b0001, 8);
        for (int j = 0; j < 6; j++) begin
            in_v = pat[j];
            @(negedge clk);
            checks++;
            if (w_obs !== m_exp) begin
                errors++;
                $display("FAIL bounce_model t=%0t got %h want %h", $time, w_obs, m_exp);
            end
            if (rise_a[1]) begin
                errors++;
                $display("FAIL bounce_early_rise got %b want 0", rise_a[1]);
            end
        end
        pulses  = 0;
        first_j = -1;
        // pat[4] is the last toggle; loop index j counts edges since it was applied.
        for (int j = 3; j <= 14; j++) begin
            @(negedge clk);
            checks++;
            if (w_obs !== m_exp) begin
                errors++;
                $display("FAIL bounce_model t=%0t got %h want %h", $time, w_obs, m_exp);
            end
            if (rise_a[1]) begin
                pulses++;
                if (first_j < 0) first_j = j;
            end
        end
        checks++;
        if (pulses !== 1 || first_j !== 6) begin
            errors++;
            $display("FAIL bounce_rise got pulses=%0d at=%0d want pulses=1 at=6", pulses, first_j);
        end
    endtask

    task automatic test_enable_gating();
        int ena_cnt;
        int exp_j;
        int rise_j;
        int bad;
        logic prev_en;
        settle(4'b0011, 6);
        ena_cnt = 0;
        exp_j   = -1;
        rise_j  = -1;
        bad     = 0;
        for (int j = 0; j < 30; j++) begin
            en = (j % 3 == 0);
            if (j == 0) in_v[3] = 1'b1;
            prev_en = en;
            if (j >= 2 && en) begin
                ena_cnt++;
                if (ena_cnt == 4) exp_j = j;
            end
            @(negedge clk);
            checks++;
            if (w_obs !== m_exp) begin
                errors++;
                $display("FAIL gate_model t=%0t got %h want %h", $time, w_obs, m_exp);
            end
            if (!prev_en && (any_a || any_b || any_c)) bad++;
            if (rise_a[3] && rise_j < 0) rise_j = j;
        end
        checks++;
        if (rise_j !== exp_j || bad !== 0) begin
            errors++;
            $display("FAIL gate_timing got at=%0d stray=%0d want at=%0d stray=0", rise_j, bad, exp_j);
        end
        en = 1'b1;
    endtask

    task automatic test_simultaneous();
        int any_cycles;
        logic [3:0] seen_fall;
        settle(4'b1111, 12);
        in_v       = 4'b0000;
        any_cycles = 0;
        seen_fall  = 4'b0000;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            checks++;
            if (w_obs !== m_exp) begin
                errors++;
                $display("FAIL simul_model t=%0t got %h want %h", $time, w_obs, m_exp);
            end
            if (any_a) begin
                any_cycles++;
                seen_fall = fall_a;
            end
        end
        checks++;
        if (any_cycles !== 1 || seen_fall !== 4'b1111) begin
            errors++;
            $display("FAIL simul_fall got cycles=%0d fall=%b want cycles=1 fall=1111",
                     any_cycles, seen_fall);
        end
    endtask

    task automatic test_reset_midcount();
        int pulses_b;
        settle(4'b0000, 10);
        in_v = 4'b1111;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_b, rise_b, fall_b, any_b} !== 13'b1111_0000_0000_0) begin
            errors++;
            $display("FAIL midreset_b got %b want %b", {out_b, rise_b, fall_b, any_b},
                     13'b1111_0000_0000_0);
        end
        checks++;
        if (w_obs !== m_exp) begin
            errors++;
            $display("FAIL midreset_model got %h want %h", w_obs, m_exp);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        pulses_b = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            checks++;
            if (w_obs !== m_exp) begin
                errors++;
                $display("FAIL midreset_model t=%0t got %h want %h", $time, w_obs, m_exp);
            end
            if (any_b || out_b !== 4'b1111) pulses_b++;
        end
        checks++;
        if (pulses_b !== 0) begin
            errors++;
            $display("FAIL midreset_release got %0d bad cycles want 0", pulses_b);
        end
    endtask

    task automatic test_stable_one();
        settle(4'b1111, 6);
        in_v[2] = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            checks++;
            if (w_obs !== m_exp) begin
                errors++;
                $display("FAIL one_model t=%0t got %h want %h", $time, w_obs, m_exp);
            end
            if (j == 2) begin
                checks++;
                if ({out_c, fall_c} !== 8'b1111_0000) begin
                    errors++;
                    $display("FAIL one_early got %b want %b", {out_c, fall_c}, 8'b1111_0000);
                end
            end
            if (j == 3) begin
                checks++;
                if ({out_c, fall_c, rise_c} !== 12'b1011_0100_0000) begin
                    errors++;
                    $display("FAIL one_accept got %b want %b", {out_c, fall_c, rise_c},
                             12'b1011_0100_0000);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (fall_c !== 4'b0000) begin
            errors++;
            $display("FAIL one_pulse_width got %b want %b", fall_c, 4'b0000);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 800; j++) begin
            @(negedge clk);
            checks++;
            if (w_obs !== m_exp) begin
                errors++;
                $display("FAIL random_model t=%0t got %h want %h", $time, w_obs, m_exp);
            end
            en = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 7) == 0) in_v[c] = ~in_v[c];
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_enable_gating();
        test_simultaneous();
        test_reset_midcount();
        test_stable_one();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deb_multi.md
DEB_MULTI -- requirements
Module: deb_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent input channels, minimum 1.
REQ-002 SHALL have parameter CNT_WIDTH, default 8: per-channel stability counter width.
REQ-003 SHALL have parameter STABLE_CNT, default 255: consecutive enabled cycles an input must hold before acceptance; legal range 1 to 2**CNT_WIDTH.
REQ-004 SHALL have parameter RESET_VAL, default 0: reset level of synchronizers and outputs, applied to all channels.
REQ-005 SHALL have port clk, input, 1: rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1: sample enable (tick), active high.
REQ-008 SHALL have port in, input, CHANNELS: raw asynchronous inputs, bit i is channel i.
REQ-009 SHALL have port out, output, CHANNELS: debounced levels.
REQ-010 SHALL have port rise, output, CHANNELS: one-cycle pulse on an accepted 0->1 change of out[i].
REQ-011 SHALL have port fall, output, CHANNELS: one-cycle pulse on an accepted 1->0 change of out[i].
REQ-012 SHALL have port any_change, output, 1: OR of all rise and fall bits.

Function
REQ-013 SHALL pass each in[i] through a 2-flop synchronizer (s1, s2) clocked every cycle regardless of en.
REQ-014 SHALL keep one CNT_WIDTH-bit counter per channel.
REQ-015 SHALL, on an edge with en=1 and s2[i]==out[i], clear cnt[i] to 0.
REQ-016 SHALL, on an edge with en=1, s2[i]!=out[i] and cnt[i]<STABLE_CNT-1, increment cnt[i] by 1.
REQ-017 SHALL, on an edge with en=1, s2[i]!=out[i] and cnt[i]==STABLE_CNT-1, load out[i]<=s2[i] and clear cnt[i] to 0.
REQ-018 SHALL, with en held 1, update out[i] at edge k+1+STABLE_CNT when in[i] changes before edge k and stays stable; with STABLE_CNT=1, at edge k+2.
REQ-019 SHALL, on an edge with en=0, hold cnt, out, and synchronizer contents unaffected apart from normal shifting, and drive rise/fall to 0.
REQ-020 SHALL register rise[i]/fall[i] so they are high exactly in the cycle in which out[i] first shows the new value, and low otherwise.
REQ-021 SHALL treat any bounce (s2[i] returning to out[i] before threshold) as a counter restart; no partial count is retained.
REQ-022 SHALL process channels fully independently; simultaneous acceptances on several channels SHALL each produce their own pulse in the same cycle.
REQ-023 SHALL never let cnt[i] exceed STABLE_CNT-1 or wrap around.
REQ-024 SHALL derive any_change combinationally from registered rise/fall.

Reset
REQ-025 SHALL, while rst_n=0, force s1, s2, out to RESET_VAL on all bits, cnt to 0, rise, fall and any_change to 0, asynchronously.
REQ-026 SHALL, when reset is asserted mid-count, discard the count; no pulse SHALL be produced by reset assertion or release.
REQ-027 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-028 SHALL cover clean press: CHANNELS=4, STABLE_CNT=4, en=1, in[0] 0->1 before edge k -> out[0]=1 and rise[0]=1 for one cycle after edge k+5; other bits 0.
REQ-029 SHALL cover bounce: in[1] toggles 1,0,1 with 2-cycle pulses, then holds 1 -> out[1] rises only 4 enabled cycles after the last toggle reaches s2; single rise pulse.
REQ-030 SHALL cover enable gating: en=1 every 3rd cycle, STABLE_CNT=4 -> out changes after 4 enabled edges; no pulse in en=0 cycles.
REQ-031 SHALL cover simultaneous events: in=4'b1111 -> 4'b0000 at once after settle -> fall=4'b1111 in one cycle, any_change=1 for exactly one cycle.
REQ-032 SHALL cover reset mid-count: rst_n low at cnt=2 with RESET_VAL=1 -> out=4'b1111, cnt=0, rise=fall=0; no pulse after release while in=4'b1111.
REQ-033 SHALL cover STABLE_CNT=1 edge case: step on in[2] -> out[2] updates at edge k+2 with a single pulse.
